// File: rtl/da_fir_seq.sv
// da_fir_seq: bit-serial distributed-arithmetic FIR sequencer (8 taps, external coefficient LUT)
module da_fir_seq #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [7:0]        lut_addr,
    input  logic [ACC_W-1:0]  lut_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
);
    localparam int JW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  x_q [8];
    logic [DATA_W-1:0]  x_d [8];
    logic [ACC_W-1:0]   acc_q, acc_d, res_q, res_d, sh;
    logic [JW-1:0]      j_q, j_d;
    logic               last;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_data  = res_q;
    assign last      = j_q == J_LAST;
    assign sh        = lut_data << j_q;

    // LUT address: bit j of every tap, only while computing
    always_comb begin
        lut_addr = '0;
        for (int k = 0; k < 8; k++)
            lut_addr[k] = (state_q == COMP) ? x_q[k][j_q] : 1'b0;
    end

    // next-state, delay line shift and shift/add accumulation
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        res_d   = res_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    x_d = '{default: '0};
                end else if (in_valid) begin
                    for (int k = 1; k < 8; k++) x_d[k] = x_q[k-1];
                    x_d[0]  = in_data;
                    acc_d   = '0;
                    j_d     = '0;
                    state_d = COMP;
                end
            end
            COMP: begin
                acc_d = last ? acc_q - sh : acc_q + sh;
                j_d   = j_q + JW'(1);
                if (last) begin
                    res_d   = acc_d;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aborts any computation and empties the delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '{default: '0};
            acc_q   <= '0;
            res_q   <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            j_q     <= j_d;
        end
    end
endmodule
